// File: rtl/uart_pkg.sv
// uart_pkg: line levels, defaults and receiver states shared by the UART transmitter and receiver
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF = 8;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL = 1'b1;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser for an asynchronous input, with a selectable reset level
module uart_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q <= RESET_VALUE;
        end else begin
            meta <= d;
            q <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 receiver; checks the start bit at half-period, samples each bit mid-period
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] FINAL_BIT = BW'(DATA_BITS - 1);

    state_t state, state_d;
    logic [TW-1:0] tick, tick_d;
    logic [BW-1:0] idx, idx_d;
    logic [DATA_BITS-1:0] shift, shift_d, data_d;
    logic valid_d, ferr_d, rx_s;

    uart_sync #(.RESET_VALUE(LINE_IDLE)) u_sync (
        .clock(clock),
        .reset(reset),
        .d(rx),
        .q(rx_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            tick <= '0;
            idx <= '0;
            shift <= '0;
            data <= '0;
            data_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state <= state_d;
            tick <= tick_d;
            idx <= idx_d;
            shift <= shift_d;
            data <= data_d;
            data_valid <= valid_d;
            frame_error <= ferr_d;
        end
    end

    always_comb begin
        state_d = state;
        tick_d = tick + 1'b1;
        idx_d = idx;
        shift_d = shift;
        data_d = data;
        valid_d = 1'b0;
        ferr_d = 1'b0;
        case (state)
            IDLE: begin
                tick_d = '0;
                state_d = (rx_s == START_LEVEL) ? START : IDLE;
            end
            START: if (tick == HALF) begin
                tick_d = '0;
                idx_d = '0;
                state_d = (rx_s == START_LEVEL) ? DATA : IDLE;
            end
            DATA: if (tick == LAST) begin
                tick_d = '0;
                shift_d = {rx_s, shift[DATA_BITS-1:1]};
                idx_d = idx + 1'b1;
                state_d = (idx == FINAL_BIT) ? STOP : DATA;
            end
            STOP: if (tick == LAST) begin
                tick_d = '0;
                valid_d = (rx_s == STOP_LEVEL);
                ferr_d = (rx_s != STOP_LEVEL);
                data_d = (rx_s == STOP_LEVEL) ? shift : data;
                state_d = (rx_s == STOP_LEVEL) ? IDLE : BREAK_WAIT;
            end
            BREAK_WAIT: begin
                // a held-low line must not be decoded as a stream of zero bytes
                tick_d = '0;
                state_d = (rx_s == LINE_IDLE) ? IDLE : BREAK_WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx at 16 clocks per bit with hand-computed expectations
module tb_uart_rx;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic [7:0] data;
    logic data_valid, frame_error, busy;

    int passed = 0, total = 0;
    int cyc = 0, nvalid = 0, nferr = 0, noverlap = 0, t0 = 0, n0 = 0, f0 = 0;
    int vtime[64];
    logic [7:0] vdata[64];
    logic after_valid = 1'b0, busy_after = 1'b1;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clock(clock),
        .reset(reset),
        .rx(rx),
        .data(data),
        .data_valid(data_valid),
        .frame_error(frame_error),
        .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (data_valid && nvalid < 64) begin
            vtime[nvalid] = cyc;
            vdata[nvalid] = data;
        end
        if (data_valid) nvalid++;
        if (frame_error) nferr++;
        if (data_valid && frame_error) noverlap++;
        if (after_valid) busy_after = busy;
        after_valid = data_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // mimics the transmitter: start, LSB-first data, stop, 16 clocks each
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            wait_cycles(16);
        end
    endtask

    initial begin
        wait_cycles(3);
        check("rst_data", data, 0);
        check("rst_valid", data_valid, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        wait_cycles(5);
        check("idle_busy", busy, 0);

        n0 = nvalid; t0 = cyc;
        send_frame(8'h40, 1'b1);
        wait_cycles(4);
        check("b40_count", nvalid - n0, 1);
        check("b40_data", vdata[n0], 8'h40);
        check("b40_latency", (vtime[n0] - t0 - 1 >= 153) && (vtime[n0] - t0 - 1 <= 155), 1);
        check("b40_busy_after", busy_after, 0);
        check("b40_ferr", nferr, 0);

        n0 = nvalid;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cycles(4);
        check("b2b_count", nvalid - n0, 2);
        check("b2b_first", vdata[n0], 8'h00);
        check("b2b_second", vdata[n0+1], 8'hFF);
        check("b2b_spacing", vtime[n0+1] - vtime[n0], 160);
        check("b2b_ferr", nferr, 0);

        n0 = nvalid; f0 = nferr;
        rx = 1'b0;
        wait_cycles(4);
        check("glitch_busy_start", busy, 1);
        rx = 1'b1;
        wait_cycles(7);
        check("glitch_busy_end", busy, 0);
        wait_cycles(20);
        check("glitch_valid", nvalid - n0, 0);
        check("glitch_ferr", nferr - f0, 0);

        n0 = nvalid; f0 = nferr;
        send_frame(8'h40, 1'b1);
        send_frame(8'h5A, 1'b0);
        wait_cycles(100);
        check("brk_ferr", nferr - f0, 1);
        check("brk_valid", nvalid - n0, 1);
        check("brk_data", data, 8'h40);
        check("brk_busy", busy, 1);
        rx = 1'b1;
        wait_cycles(4);
        check("brk_release_busy", busy, 0);
        send_frame(8'h33, 1'b1);
        wait_cycles(2);
        check("brk_next_data", data, 8'h33);
        check("brk_next_ferr", nferr - f0, 1);

        n0 = nvalid; f0 = nferr;
        rx = 1'b0;
        wait_cycles(16);
        rx = 1'b0;
        wait_cycles(48);
        rx = 1'b1;
        wait_cycles(8);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        check("mrst_data", data, 0);
        check("mrst_valid", data_valid, 0);
        check("mrst_ferr", frame_error, 0);
        check("mrst_busy", busy, 0);
        wait_cycles(8 + 16 * 5);
        check("mrst_ignored", nvalid - n0, 0);
        send_frame(8'hA5, 1'b1);
        wait_cycles(2);
        check("mrst_next_count", nvalid - n0, 1);
        check("mrst_next_data", data, 8'hA5);

        n0 = nvalid;
        send_frame(8'h01, 1'b1);
        send_frame(8'h80, 1'b1);
        send_frame(8'h55, 1'b1);
        wait_cycles(4);
        check("loop_count", nvalid - n0, 3);
        check("loop_0", vdata[n0], 8'h01);
        check("loop_1", vdata[n0+1], 8'h80);
        check("loop_2", vdata[n0+2], 8'h55);
        check("loop_ferr", nferr - f0, 0);
        check("no_overlap", noverlap, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
